matrix_multiplier_nxn: RTL and testbench
========================================

Name: matrix_multiplier_nxn

Overview:
- Parametrised sequential successor to the fixed 2x2, 3-bit matrix multiplier.
- Computes C = A x B for square NxN unsigned matrices using one shared multiply-accumulate (MAC) unit, one MAC per cycle.
- Streams each result element out over a valid/ready port with its linear index, and also holds the full flattened result.
- Sits between the operand source (switch or register inputs) and the result display/handler logic.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 3, operand element width in bits.
- RW, 2*W+$clog2(N), result element width (derived, not overridable); never overflows for unsigned operands.
- IW, $clog2(N*N), result index width (derived).

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- matrix_a  in  N*N*W  operand A; element (r,c) at bits [(r*N+c)*W +: W].
- matrix_b  in  N*N*W  operand B; same packing as matrix_a.
- start  in  1  begin a multiply; sampled only in IDLE.
- busy  out  1  high in MAC and EMIT states.
- done  out  1  one-cycle pulse after the final element handshake.
- res_valid  out  1  res_data/res_index are valid.
- res_ready  in  1  consumer accepts the element.
- res_data  out  RW  current result element C[i][j].
- res_index  out  IW  i*N+j of res_data.
- matrix_result  out  N*N*RW  full result, same packing; element (i,j) written at its handshake.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, res_valid = 0; res_data, res_index, matrix_result = 0; i, j, k counters and accumulator = 0.
- States: IDLE, MAC, EMIT, DONE.
- IDLE:
  - start=1 at an edge captures matrix_a and matrix_b into internal operand registers, clears i, j, k and the accumulator, and moves to MAC.
  - Operand inputs may change freely after the capture edge.
  - matrix_result holds the previous product until overwritten element by element.
- MAC:
  - Each cycle: acc <= acc + A[i][k]*B[k][j]; the first cycle of each element (k==0) loads the product instead of adding.
  - The multiply is W x W to 2W bits; accumulation is zero-extended to RW.
  - When k==N-1: k<=0, go to EMIT. The element therefore takes exactly N MAC cycles.
- EMIT:
  - res_valid=1; res_data=acc; res_index=i*N+j. These values are stable until the handshake.
  - Handshake is res_valid & res_ready at an edge. On handshake: write acc into matrix_result slot (i,j); advance j, wrapping to 0 and incrementing i; return to MAC.
  - If (i,j)==(N-1,N-1), go to DONE instead.
  - While res_ready=0, stay in EMIT with all outputs held (backpressure, no loss).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency:
  - The first MAC cycle is the cycle after the start edge.
  - With res_ready tied high, each element takes N+1 cycles and done is asserted N*N*(N+1) cycles after the start edge (12 for N=2).
- start while busy or in DONE is ignored; no queuing.
- Reset mid-operation aborts immediately; no done pulse, and the partial result is discarded (matrix_result = 0).
- All outputs are registered; no combinational path from res_ready to res_valid.

Decomposition:
- Shared package matmul_pkg:
  - state enum (IDLE, MAC, EMIT, DONE);
  - width helper functions for RW and IW;
  - element slice/index helper function.
- Sub-module mac_unit (parameters W, RW): inputs clock, reset, clear_load, en, a, b; output acc. The FSM, counters and operand registers stay in the top module.

Test Plan:
- N=2, W=3, res_ready=1; A=[[1,2],[3,4]], B=[[5,6],[7,7]]; start -> indices 0..3 emit 19, 20, 43, 46; done exactly 12 cycles after the start edge; matrix_result packs {46,43,20,19}.
- N=2, W=3, all elements 7 -> every element = 98 (fits RW=7, no wrap); done pulses once.
- Backpressure: hold res_ready=0 for 5 cycles at index 1 -> res_valid, res_data=20 and res_index=1 stay stable; no element lost or duplicated; done is delayed by 5 cycles.
- Assert reset during MAC of element 2 -> busy, res_valid, done and matrix_result go to 0 asynchronously; a following start recomputes the correct result.
- start pulses while busy and in the DONE cycle -> ignored; exactly one done per accepted start.
- N=3, W=4; A=identity, B=[[1..9]] -> outputs 1..9 in index order; done after 36 cycles.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential NxN matrix multiplier.
package matmul_pkg;

  // Controller states of the multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Result element width: a W x W product summed N times never needs more.
  function automatic int res_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Width of the linear result index i*N+j.
  function automatic int idx_width(input int n);
    return $clog2(n * n);
  endfunction

  // Width of the i/j/k loop counters.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  // Bit offset of element (r,c) inside a flattened row-major matrix.
  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/matrix_multiplier_nxn_mac_unit.sv
// Single multiply-accumulate stage shared by every result element.
module mac_unit #(
  parameter int W  = 3,
  parameter int RW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_load,
  input  logic          en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [RW-1:0] acc
);

  logic [2*W-1:0] prod;

  assign prod = a * b;

  // en+clear_load loads the product, en alone accumulates, clear_load alone zeroes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      if (clear_load) begin
        acc <= RW'(prod);
      end else begin
        acc <= acc + RW'(prod);
      end
    end else if (clear_load) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/matrix_multiplier_nxn.sv
// Sequential C = A x B for unsigned NxN matrices, one MAC per cycle,
// streaming each element over valid/ready and keeping the full result.
module matrix_multiplier_nxn
  import matmul_pkg::*;
#(
  parameter int  N  = 2,
  parameter int  W  = 3,
  localparam int RW = res_width(N, W),
  localparam int IW = idx_width(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N*N*W-1:0]  matrix_a,
  input  logic [N*N*W-1:0]  matrix_b,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_data,
  output logic [IW-1:0]     res_index,
  output logic [N*N*RW-1:0] matrix_result
);

  localparam int CW = cnt_width(N);

  state_t             state_reg;
  logic [CW-1:0]      i_reg;
  logic [CW-1:0]      j_reg;
  logic [CW-1:0]      k_reg;
  logic [N*N*W-1:0]   a_reg;
  logic [N*N*W-1:0]   b_reg;
  logic [W-1:0]       a_elem [N][N];
  logic [W-1:0]       b_elem [N][N];
  logic [RW-1:0]      res_mem [N*N];
  logic               mac_en;
  logic               mac_clear;

  // Unpack the captured operands so the MAC operands are plain array reads.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_elem[gi][gj] = a_reg[elem_lsb(gi, gj, N, W) +: W];
      assign b_elem[gi][gj] = b_reg[elem_lsb(gi, gj, N, W) +: W];
    end
  end

  // Flatten the stored result elements onto the output bus.
  for (genvar gi = 0; gi < N * N; gi++) begin : g_res
    assign matrix_result[gi*RW +: RW] = res_mem[gi];
  end

  assign mac_en    = (state_reg == MAC);
  assign mac_clear = ((state_reg == IDLE) && start) ||
                     ((state_reg == MAC) && (k_reg == '0));

  // The accumulator is a register and is held during EMIT, so it drives res_data directly.
  mac_unit #(
    .W  (W),
    .RW (RW)
  ) u_mac (
    .clock      (clock),
    .reset      (reset),
    .clear_load (mac_clear),
    .en         (mac_en),
    .a          (a_elem[i_reg][k_reg]),
    .b          (b_elem[k_reg][j_reg]),
    .acc        (res_data)
  );

  // Controller: operand capture, loop counters, result handshake and stored result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_index <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int n = 0; n < N * N; n++) begin
        res_mem[n] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= matrix_a;
            b_reg     <= matrix_b;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            res_index <= '0;
            busy      <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (k_reg == CW'(N - 1)) begin
            k_reg     <= '0;
            res_valid <= 1'b1;
            state_reg <= EMIT;
          end else begin
            k_reg <= k_reg + CW'(1);
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_mem[res_index] <= res_data;
            res_valid          <= 1'b0;
            if (res_index == IW'(N * N - 1)) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              res_index <= res_index + IW'(1);
              if (j_reg == CW'(N - 1)) begin
                j_reg <= '0;
                i_reg <= i_reg + CW'(1);
              end else begin
                j_reg <= j_reg + CW'(1);
              end
              state_reg <= MAC;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiplier_nxn.sv
// Scoreboard bench for matrix_multiplier_nxn at N=2/W=3 and N=3/W=4.
module tb_matrix_multiplier_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [11:0] a2, b2;
  logic        start2, busy2, done2, valid2, rdy2;
  logic [6:0]  data2;
  logic [1:0]  idx2;
  logic [27:0] mres2;

  logic [35:0] a3, b3;
  logic        start3, busy3, done3, valid3, rdy3;
  logic [9:0]  data3;
  logic [3:0]  idx3;
  logic [89:0] mres3;

  matrix_multiplier_nxn #(.N(2), .W(3)) dut2 (
    .clock(clk), .reset(rst), .matrix_a(a2), .matrix_b(b2), .start(start2),
    .busy(busy2), .done(done2), .res_valid(valid2), .res_ready(rdy2),
    .res_data(data2), .res_index(idx2), .matrix_result(mres2)
  );

  matrix_multiplier_nxn #(.N(3), .W(4)) dut3 (
    .clock(clk), .reset(rst), .matrix_a(a3), .matrix_b(b3), .start(start3),
    .busy(busy3), .done(done3), .res_valid(valid3), .res_ready(rdy3),
    .res_data(data3), .res_index(idx3), .matrix_result(mres3)
  );

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t         q2[$];
  exp_t         q3[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cnt2 = 0, done_cnt3 = 0;
  int           done_cyc2 = 0, done_cyc3 = 0;
  int           done_prev2 = 0, done_prev3 = 0;
  int           start_cyc = 0;
  logic [127:0] exp_res2, exp_res3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product; pushes expected elements in index order and the packed result.
  task automatic model(input int n, input int w, input int rw,
                       input logic [127:0] a, input logic [127:0] b, input bit to3);
    logic [127:0] res;
    int           s, av, bv;
    exp_t         e;
    res = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          av = int'(a >> ((r * n + k) * w)) & ((1 << w) - 1);
          bv = int'(b >> ((k * n + c) * w)) & ((1 << w) - 1);
          s += av * bv;
        end
        e.idx = r * n + c;
        e.val = s;
        if (to3) q3.push_back(e); else q2.push_back(e);
        res = res | (128'(unsigned'(s)) << ((r * n + c) * rw));
      end
    end
    if (to3) exp_res3 = res; else exp_res2 = res;
  endtask

  // N=2 monitor: done pulses, backpressure stability, scoreboard pops.
  logic       stall2 = 1'b0;
  logic [6:0] hold_d2;
  logic [1:0] hold_i2;
  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      done_cnt2++;
      done_cyc2 = cyc;
    end
    if (stall2) begin
      check("hold_valid", valid2, 1);
      check("hold_data", data2, hold_d2);
      check("hold_index", idx2, hold_i2);
    end
    stall2  = (valid2 === 1'b1) && !rdy2;
    hold_d2 = data2;
    hold_i2 = idx2;
    if ((valid2 === 1'b1) && rdy2) begin
      checks++;
      assert (q2.size() > 0) else begin
        errors++;
        $error("FAIL extra_elem2: observed index %0d data %0d, expected no element", idx2, data2);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        $display("n2 element index %0d data %0d (expected %0d/%0d)", idx2, data2, e.idx, e.val);
        check("elem2_index", idx2, e.idx);
        check("elem2_data", data2, e.val);
      end
    end
  end

  // N=3 monitor.
  always @(negedge clk) begin
    exp_t e;
    if (done3 === 1'b1) begin
      done_cnt3++;
      done_cyc3 = cyc;
    end
    if ((valid3 === 1'b1) && rdy3) begin
      checks++;
      assert (q3.size() > 0) else begin
        errors++;
        $error("FAIL extra_elem3: observed index %0d data %0d, expected no element", idx3, data3);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        $display("n3 element index %0d data %0d (expected %0d/%0d)", idx3, data3, e.idx, e.val);
        check("elem3_index", idx3, e.idx);
        check("elem3_data", data3, e.val);
      end
    end
  end

  task automatic go2();
    done_prev2 = done_cnt2;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start2 = 1'b0;
    a2 = ~a2;
    b2 = ~b2;
    check("busy_after_start", busy2, 1);
  endtask

  task automatic finish2(input string tag, input int exp_lat);
    for (int n = 0; n < 200 && done_cnt2 == done_prev2; n++) @(posedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt2, done_prev2 + 1);
    check({tag, "_latency"}, done_cyc2 - start_cyc, exp_lat);
    check({tag, "_queue_empty"}, q2.size(), 0);
    check({tag, "_matrix_result"}, mres2, exp_res2);
    check({tag, "_busy_low"}, busy2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a2 = '0; b2 = '0; start2 = 1'b0; rdy2 = 1'b1;
    a3 = '0; b3 = '0; start3 = 1'b0; rdy3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_valid", valid2, 0);
    check("rst_data", data2, 0);
    check("rst_index", idx2, 0);
    check("rst_result", mres2, 0);
    check("rst_busy3", busy3, 0);
    check("rst_result3", mres3, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A=[[1,2],[3,4]], B=[[5,6],[7,7]] -> 19,20,43,46
    a2 = {3'd4, 3'd3, 3'd2, 3'd1};
    b2 = {3'd7, 3'd7, 3'd6, 3'd5};
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    check("model_sanity", exp_res2, {7'd46, 7'd43, 7'd20, 7'd19});
    go2();
    finish2("basic", 12);

    // All elements 7 -> 98 everywhere.
    a2 = '1;
    b2 = '1;
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    go2();
    finish2("all7", 12);

    // Backpressure for 5 cycles on index 1.
    a2 = {3'd4, 3'd3, 3'd2, 3'd1};
    b2 = {3'd7, 3'd7, 3'd6, 3'd5};
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    go2();
    repeat (5) @(posedge clk);
    #1;
    rdy2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rdy2 = 1'b1;
    finish2("backpressure", 17);

    // Reset during MAC of element 2.
    a2 = {3'd1, 3'd2, 3'd3, 3'd4};
    b2 = {3'd5, 3'd6, 3'd7, 3'd1};
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    go2();
    repeat (7) @(posedge clk);
    #2;
    check("elems_before_reset", q2.size(), 2);
    rst = 1'b1;
    #1;
    check("abort_busy", busy2, 0);
    check("abort_valid", valid2, 0);
    check("abort_done", done2, 0);
    check("abort_result", mres2, 0);
    q2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_no_done", done_cnt2, done_prev2);
    a2 = {3'd1, 3'd2, 3'd3, 3'd4};
    b2 = {3'd5, 3'd6, 3'd7, 3'd1};
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    go2();
    finish2("after_reset", 12);

    // Start pulses while busy and during the DONE cycle are ignored.
    a2 = {3'd2, 3'd5, 3'd0, 3'd3};
    b2 = {3'd6, 3'd1, 3'd4, 3'd7};
    model(2, 3, 7, 128'(a2), 128'(b2), 1'b0);
    go2();
    repeat (3) @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    finish2("ignored_start", 12);
    repeat (10) @(posedge clk);
    #1;
    check("ignored_start_idle", busy2, 0);
    check("ignored_start_one_done", done_cnt2, done_prev2 + 1);

    // N=3: identity x [[1..9]] -> 1..9 in index order.
    a3 = '0;
    b3 = '0;
    for (int r = 0; r < 3; r++) a3[(r * 3 + r) * 4 +: 4] = 4'd1;
    for (int n = 0; n < 9; n++) b3[n * 4 +: 4] = 4'(n + 1);
    model(3, 4, 10, 128'(a3), 128'(b3), 1'b1);
    done_prev3 = done_cnt3;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start3 = 1'b0;
    a3 = '1;
    b3 = '0;
    for (int n = 0; n < 300 && done_cnt3 == done_prev3; n++) @(posedge clk);
    #1;
    check("n3_done_count", done_cnt3, done_prev3 + 1);
    check("n3_latency", done_cyc3 - start_cyc, 36);
    check("n3_queue_empty", q3.size(), 0);
    check("n3_matrix_result", mres3, exp_res3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
